// File: rtl/sonar_sched.sv
`default_nettype none
// ============================================================================
// Module : sonar_sched
// Two-channel ultrasonic range scheduler (ch0 = pitch, ch1 = volume) sharing
// one trigger/echo-width engine. Optional SONAR_AVG_EN: 2-sample width averaging.
// Rev    : 1.0
// ============================================================================
module sonar_sched #(
  parameter int PRESC     = 100,
  parameter int TRIG_CYC  = 1000,
  parameter int TO_TICKS  = 6000,
  parameter int GAP_TICKS = 500,
  parameter int DEFAULT_W = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  echo,
  output logic [1:0]  trig,
  output logic [12:0] width0,
  output logic [12:0] width1,
  output logic [1:0]  valid,
  output logic [1:0]  timeout,
  output logic        busy
);

  localparam int C_PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int C_TW = (TRIG_CYC > 1) ? $clog2(TRIG_CYC) : 1;
  localparam int C_OW = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;
  localparam int C_GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int C_CW = (C_OW > C_GW) ? C_OW : C_GW;

  localparam logic [C_PW-1:0] C_PRESC_LAST = C_PW'(PRESC - 1);
  localparam logic [C_TW-1:0] C_TRIG_LAST  = C_TW'(TRIG_CYC - 1);
  localparam logic [C_CW-1:0] C_TO_LAST    = C_CW'(TO_TICKS - 1);
  localparam logic [C_CW-1:0] C_GAP_LAST   = C_CW'(GAP_TICKS - 1);
  localparam logic [12:0]     C_WMAX       = 13'h1FFF;
  localparam logic [12:0]     C_DEF        = 13'(DEFAULT_W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TRIG = 3'd1,
    S_WAIT = 3'd2,
    S_MEAS = 3'd3,
    S_TOUT = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               ch_q, ch_d;
  logic [1:0]         echo_s1_q, echo_s1_d;
  logic [1:0]         echo_s2_q, echo_s2_d;
  logic [C_PW-1:0]    presc_q, presc_d;
  logic [C_TW-1:0]    trig_cnt_q, trig_cnt_d;
  logic [C_CW-1:0]    tcnt_q, tcnt_d;
  logic               armed_q, armed_d;
  logic [12:0]        wcnt_q, wcnt_d;
  logic [1:0][12:0]   width_q, width_d;
  logic [1:0]         valid_q, valid_d;
  logic [1:0]         timeout_q, timeout_d;
`ifdef SONAR_AVG_EN
  logic [1:0][12:0]   raw_prev_q, raw_prev_d;
  logic [13:0]        w_sum;
`endif

  logic               w_e;
  logic               w_tick;
  logic               w_upd;
  logic [12:0]        w_upd_raw;

  assign w_e    = echo_s2_q[ch_q];
  assign w_tick = (presc_q == C_PRESC_LAST);

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    echo_s1_d  = echo;
    echo_s2_d  = echo_s1_q;
    presc_d    = w_tick ? '0 : presc_q + 1'b1;
    trig_cnt_d = trig_cnt_q;
    tcnt_d     = tcnt_q;
    armed_d    = armed_q;
    wcnt_d     = wcnt_q;
    width_d    = width_q;
    valid_d    = 2'b00;
    timeout_d  = timeout_q;
    w_upd      = 1'b0;
    w_upd_raw  = C_DEF;
`ifdef SONAR_AVG_EN
    raw_prev_d = raw_prev_q;
    w_sum      = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_TRIG;
      end
      S_TRIG: begin
        trig_cnt_d = trig_cnt_q + 1'b1;
        if (trig_cnt_q == C_TRIG_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        // An echo already high on entry must first be seen low (armed).
        if (armed_q && w_e) begin
          state_d = S_MEAS;
        end else if (w_tick && (tcnt_q == C_TO_LAST)) begin
          state_d = S_TOUT;
        end else begin
          if (!w_e)   armed_d = 1'b1;
          if (w_tick) tcnt_d  = tcnt_q + 1'b1;
        end
      end
      S_MEAS: begin
        if (!w_e) begin
          w_upd             = 1'b1;
          w_upd_raw         = wcnt_q;
          timeout_d[ch_q]   = 1'b0;
          state_d           = S_GAP;
        end else if (wcnt_q == C_WMAX) begin
          state_d = S_TOUT;
        end else if (w_tick) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_TOUT: begin
        w_upd           = 1'b1;
        w_upd_raw       = C_DEF;
        timeout_d[ch_q] = 1'b1;
        state_d         = S_GAP;
      end
      S_GAP: begin
        if (w_tick && (tcnt_q == C_GAP_LAST)) begin
          ch_d    = ~ch_q;
          state_d = enable ? S_TRIG : S_IDLE;
        end else if (w_tick) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_upd) begin
      valid_d[ch_q] = 1'b1;
`ifdef SONAR_AVG_EN
      w_sum              = {1'b0, w_upd_raw} + {1'b0, raw_prev_q[ch_q]};
      width_d[ch_q]      = 13'(w_sum >> 1);
      raw_prev_d[ch_q]   = w_upd_raw;
`else
      width_d[ch_q]      = w_upd_raw;
`endif
    end

    // Every state starts with fresh prescaler and counters.
    if (state_d != state_q) begin
      presc_d    = '0;
      trig_cnt_d = '0;
      tcnt_d     = '0;
      armed_d    = 1'b0;
      wcnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ch_q       <= 1'b0;
      echo_s1_q  <= 2'b00;
      echo_s2_q  <= 2'b00;
      presc_q    <= '0;
      trig_cnt_q <= '0;
      tcnt_q     <= '0;
      armed_q    <= 1'b0;
      wcnt_q     <= '0;
      width_q    <= {C_DEF, C_DEF};
      valid_q    <= 2'b00;
      timeout_q  <= 2'b00;
`ifdef SONAR_AVG_EN
      raw_prev_q <= {C_DEF, C_DEF};
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      echo_s1_q  <= echo_s1_d;
      echo_s2_q  <= echo_s2_d;
      presc_q    <= presc_d;
      trig_cnt_q <= trig_cnt_d;
      tcnt_q     <= tcnt_d;
      armed_q    <= armed_d;
      wcnt_q     <= wcnt_d;
      width_q    <= width_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
`ifdef SONAR_AVG_EN
      raw_prev_q <= raw_prev_d;
`endif
    end
  end

  assign trig    = (state_q == S_TRIG) ? (ch_q ? 2'b10 : 2'b01) : 2'b00;
  assign width0  = width_q[0];
  assign width1  = width_q[1];
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sonar_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_sonar_sched
// Directed self-checking bench for sonar_sched with a small tick configuration.
// Rev    : 1.0
// ============================================================================
module tb_sonar_sched;

  localparam int PRESC     = 4;
  localparam int TRIG_CYC  = 3;
  localparam int TO_TICKS  = 20;
  localparam int GAP_TICKS = 5;
  localparam int DEFAULT_W = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  echo;
  logic [1:0]  trig;
  logic [12:0] width0;
  logic [12:0] width1;
  logic [1:0]  valid;
  logic [1:0]  timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sonar_sched #(
    .PRESC    (PRESC),
    .TRIG_CYC (TRIG_CYC),
    .TO_TICKS (TO_TICKS),
    .GAP_TICKS(GAP_TICKS),
    .DEFAULT_W(DEFAULT_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .echo   (echo),
    .trig   (trig),
    .width0 (width0),
    .width1 (width1),
    .valid  (valid),
    .timeout(timeout),
    .busy   (busy)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 trig[b] high, 1 valid[b] high, 2 trig[b] low, 3 busy low
  task automatic wait_for(input int kind, input int b, input int limit,
                          output bit found, output int n);
    found = 1'b0;
    n = 0;
    while (!found && n < limit) begin
      @(negedge clk);
      n++;
      case (kind)
        0:       found = trig[b];
        1:       found = valid[b];
        2:       found = !trig[b];
        default: found = !busy;
      endcase
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b0; echo = 2'b00;
    cycles(3);
    checks++;
    if ({trig, busy, valid, timeout, width0, width1} !==
        {2'b00, 1'b0, 2'b00, 2'b00, 13'd300, 13'd300}) begin
      errors++;
      $display("FAIL reset_hold: got trig=%b busy=%b valid=%b to=%b w0=%0d w1=%0d expected 0/0/0/0/300/300",
               trig, busy, valid, timeout, width0, width1);
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if ({trig, busy, valid, width0, width1} !== {2'b00, 1'b0, 2'b00, 13'd300, 13'd300}) begin
        errors++;
        $display("FAIL idle_after_reset: got trig=%b busy=%b valid=%b w0=%0d w1=%0d expected 0/0/0/300/300",
                 trig, busy, valid, width0, width1);
      end
    end
  endtask

  task automatic test_measure;
    bit f; int n;
    enable = 1'b1;
    wait_for(0, 0, 20, f, n);
    checks++;
    if (f !== 1'b1 || trig[1] !== 1'b0) begin
      errors++;
      $display("FAIL trig0_start: got found=%b trig=%b expected 1/01", f, trig);
    end
    wait_for(2, 0, 20, f, n);
    checks++;
    if (n !== TRIG_CYC) begin
      errors++;
      $display("FAIL trig0_len: got %0d expected %0d", n, TRIG_CYC);
    end
    cycles(10);
    echo[0] = 1'b1;
    cycles(40);
    echo[0] = 1'b0;
    wait_for(1, 0, 10, f, n);
    checks++;
    if (n !== 3 || f !== 1'b1) begin
      errors++;
      $display("FAIL valid0_latency: got %0d expected 3", n);
    end
    checks++;
    if (!(width0 >= 13'd9 && width0 <= 13'd11) || timeout[0] !== 1'b0 || valid !== 2'b01) begin
      errors++;
      $display("FAIL meas0: got w0=%0d to0=%b valid=%b expected 9..11/0/01", width0, timeout[0], valid);
    end
    @(negedge clk);
    checks++;
    if (valid !== 2'b00) begin
      errors++;
      $display("FAIL valid0_pulse: got %b expected 00", valid);
    end
    wait_for(0, 1, 100, f, n);
    checks++;
    if (f !== 1'b1 || n !== 19) begin
      errors++;
      $display("FAIL gap_to_trig1: got %0d expected 19", n);
    end
  endtask

  task automatic test_echo_preheld;
    bit f; int n;
    echo = 2'b11;
    wait_for(2, 1, 20, f, n);
    cycles(30);
    echo = 2'b00;
    cycles(8);
    echo[1] = 1'b1;
    cycles(16);
    echo[1] = 1'b0;
    wait_for(1, 1, 10, f, n);
    checks++;
    if (f !== 1'b1 || n !== 3) begin
      errors++;
      $display("FAIL valid1_preheld: got found=%b n=%0d expected 1/3", f, n);
    end
    checks++;
    if (!(width1 >= 13'd3 && width1 <= 13'd5) || timeout[1] !== 1'b0 || width0 < 13'd9 || width0 > 13'd11) begin
      errors++;
      $display("FAIL meas1_preheld: got w1=%0d to1=%b w0=%0d expected 3..5/0/9..11", width1, timeout[1], width0);
    end
    wait_for(0, 0, 100, f, n);
  endtask

  task automatic test_timeout;
    bit f; int n;
    echo = 2'b00;
    wait_for(2, 0, 20, f, n);
    wait_for(1, 0, 200, f, n);
    checks++;
    if (f !== 1'b1 || n !== 81) begin
      errors++;
      $display("FAIL timeout0_time: got found=%b n=%0d expected 1/81", f, n);
    end
    checks++;
    if (width0 !== 13'd300 || timeout !== 2'b01) begin
      errors++;
      $display("FAIL timeout0: got w0=%0d to=%b expected 300/01", width0, timeout);
    end
    wait_for(0, 1, 100, f, n);
    checks++;
    if (f !== 1'b1) begin
      errors++;
      $display("FAIL trig1_after_timeout: got %b expected 1", f);
    end
  endtask

  task automatic test_saturate;
    bit f; int n;
    wait_for(2, 1, 20, f, n);
    cycles(5);
    echo[1] = 1'b1;
    wait_for(1, 1, 40000, f, n);
    echo[1] = 1'b0;
    checks++;
    if (f !== 1'b1 || n < 32760 || n > 32780) begin
      errors++;
      $display("FAIL sat1_time: got found=%b n=%0d expected 1/32760..32780", f, n);
    end
    checks++;
    if (width1 !== 13'd300 || timeout[1] !== 1'b1) begin
      errors++;
      $display("FAIL sat1: got w1=%0d to1=%b expected 300/1", width1, timeout[1]);
    end
    wait_for(0, 0, 100, f, n);
  endtask

  task automatic test_timeout_clear;
    bit f; int n;
    wait_for(2, 0, 20, f, n);
    cycles(4);
    echo[0] = 1'b1;
    cycles(20);
    echo[0] = 1'b0;
    wait_for(1, 0, 10, f, n);
    checks++;
    if (f !== 1'b1 || width0 !== 13'd4 || timeout !== 2'b10) begin
      errors++;
      $display("FAIL timeout0_clear: got found=%b w0=%0d to=%b expected 1/4/10", f, width0, timeout);
    end
    wait_for(0, 1, 100, f, n);
  endtask

  task automatic test_enable_drop;
    bit f; int n;
    bit seen;
    wait_for(2, 1, 20, f, n);
    cycles(3);
    echo[1] = 1'b1;
    cycles(10);
    enable = 1'b0;
    cycles(14);
    echo[1] = 1'b0;
    wait_for(1, 1, 10, f, n);
    checks++;
    if (f !== 1'b1 || width1 !== 13'd5 || timeout[1] !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_meas: got found=%b w1=%0d to1=%b expected 1/5/0", f, width1, timeout[1]);
    end
    wait_for(3, 0, 100, f, n);
    checks++;
    if (f !== 1'b1 || n !== 20) begin
      errors++;
      $display("FAIL en_drop_idle: got found=%b n=%0d expected 1/20", f, n);
    end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (trig !== 2'b00 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_quiet: got activity=%b expected 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    bit f; int n;
    enable = 1'b1;
    wait_for(0, 0, 20, f, n);
    wait_for(2, 0, 20, f, n);
    cycles(3);
    echo[0] = 1'b1;
    cycles(20);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({trig, busy, valid, timeout, width0, width1} !==
        {2'b00, 1'b0, 2'b00, 2'b00, 13'd300, 13'd300}) begin
      errors++;
      $display("FAIL reset_async: got trig=%b busy=%b valid=%b to=%b w0=%0d w1=%0d expected 0/0/0/0/300/300",
               trig, busy, valid, timeout, width0, width1);
    end
    echo = 2'b00;
    enable = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(10);
    checks++;
    if (busy !== 1'b0 || trig !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got busy=%b trig=%b expected 0/00", busy, trig);
    end
  endtask

`ifdef SONAR_AVG_EN
  task automatic test_avg;
    bit f; int n;
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    enable = 1'b1;
    wait_for(0, 0, 20, f, n);
    wait_for(2, 0, 20, f, n);
    cycles(4);
    echo[0] = 1'b1;
    cycles(402);
    echo[0] = 1'b0;
    wait_for(1, 0, 10, f, n);
    checks++;
    if (width0 !== 13'd200) begin
      errors++;
      $display("FAIL avg_first: got %0d expected 200", width0);
    end
    wait_for(0, 1, 100, f, n);
    wait_for(1, 1, 200, f, n);
    checks++;
    if (width1 !== 13'd300) begin
      errors++;
      $display("FAIL avg_timeout1: got %0d expected 300", width1);
    end
    wait_for(0, 0, 100, f, n);
    wait_for(2, 0, 20, f, n);
    cycles(4);
    echo[0] = 1'b1;
    cycles(806);
    echo[0] = 1'b0;
    wait_for(1, 0, 10, f, n);
    checks++;
    if (width0 !== 13'd150) begin
      errors++;
      $display("FAIL avg_second: got %0d expected 150", width0);
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_measure;
    test_echo_preheld;
    test_timeout;
    test_saturate;
    test_timeout_clear;
    test_enable_drop;
    test_reset_mid;
`ifdef SONAR_AVG_EN
    test_avg;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
